// File: rtl/serial_sub.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_sub
//
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, processed LSB-first
// through one full-subtractor cell and a borrow flip-flop, one bit per clock.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   defined   -> output port ovf (signed overflow of the subtraction) exists
//   undefined -> ovf port and its logic are absent; all else identical
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      request; accepted only in IDLE or in the DONE cycle
//   a      in   WIDTH  minuend, captured on the accepting edge
//   b      in   WIDTH  subtrahend, captured on the accepting edge
//   bin    in   1      borrow-in, captured on the accepting edge
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, result valid
//   diff   out  WIDTH  difference, held until the next accepted start
//   bout   out  1      final borrow-out, held like diff
//   ovf    out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
//
// Timing: start accepted at edge E0, bit i computed at E(i+1), done high
// after E(WIDTH). One operation per WIDTH+1 cycles; back-to-back possible by
// holding start during the done cycle. All outputs are registered.
// -----------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_busy;
    logic             r_done;
    logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    // Full-subtractor cell on the current LSBs of the operand shifters.
    logic w_x;
    logic w_y;
    logic w_d;
    logic w_br_next;
    logic w_last;

    assign w_x       = r_a[0];
    assign w_y       = r_b[0];
    assign w_d       = w_x ^ w_y ^ r_br;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    // Counter holds the index of the bit being processed this cycle.
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse; only the last shift edge raises it.
            r_done <= 1'b0;
            case (r_state)
                // The done cycle accepts a new request exactly like idle,
                // which is what makes back-to-back operations possible.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_diff  <= '0;
                        r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                // start is deliberately not looked at here: requests during
                // processing are dropped, not queued.
                S_SHIFT: begin
                    // New bit enters at the MSB so the first (LSB) result
                    // bit has walked down to diff[0] after WIDTH shifts.
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bout  <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // Operands of different sign and the result sign
                        // differs from the minuend: signed overflow.
                        r_ovf   <= (w_x != w_y) && (w_d != w_x);
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit subtractor that computes `diff = a - b - bin` LSB-first through a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's gate-level full-adder cells: one 1-bit cell reused over WIDTH cycles, under a start/busy/done handshake. It sits between an operand source that presents parallel words and a consumer that samples the result on `done`.

## Interface
- `WIDTH`, default 8, operand/result width in bits (legal range 2..32).

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when idle or in the done cycle
- `a`  in  WIDTH  minuend; sampled on the accepting edge only
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only
- `bin`  in  1  borrow-in; sampled on the accepting edge only
- `busy`  out  1  high while bits are being processed
- `done`  out  1  one-cycle pulse; result valid
- `diff`  out  WIDTH  difference; held until the next accepted start
- `bout`  out  1  final borrow-out (1 = unsigned a < b + bin); held like `diff`
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`

## Operation
- FSM states: IDLE, SHIFT, DONE. State encoding is free.
- IDLE: on `start=1`, load the shift registers `ra<=a` and `rb<=b`, set `br<=bin`, clear the bit counter and `diff`, then go to SHIFT. With `start=0`, stay in IDLE.
- SHIFT: each cycle, take `x=ra[0]` and `y=rb[0]`.
  - `d = x^y^br`
  - `br <= (~x&y) | (~(x^y)&br)`
  - Shift `d` into `diff` at the MSB, so after WIDTH shifts bit 0 lands in `diff[0]`.
  - Shift `ra` and `rb` right and increment the counter.
  - After the WIDTH-th bit, go to DONE.
- DONE: `done=1` for exactly this cycle. `bout` equals `br`.
  - `start=1` here is accepted exactly as in IDLE, so back-to-back operations are possible.
  - Otherwise return to IDLE.
- `start` while in SHIFT is ignored. It is neither queued nor an error.
- All arithmetic is modulo 2^WIDTH. `{bout,diff}` equals the (WIDTH+1)-bit two's-complement result of `a - b - bin`.
- X/Z on `a`, `b` or `bin` at acceptance propagates into `diff` and `bout`. No X masking.

## Timing
- Start accepted at edge E0. `busy` rises after E0 and stays high through edge E(WIDTH).
- Bit i is computed at edge E(i+1).
- After E(WIDTH): `busy=0`, `done=1`, and `diff`/`bout` are final.
- After E(WIDTH+1): `done=0`.
- Latency from accepting edge to `done` high is WIDTH cycles. Throughput is one operation per WIDTH+1 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: `busy=0`, `done=0`, `diff=0`, `bout=0`, `ovf=0`, state IDLE, counter 0.
- Reset mid-operation: on the next edge with `rst=1`, all of the above take their reset values. The partial result is discarded, and no `done` pulse is produced for the aborted operation.
- `rst` and `start` high on the same edge: reset wins, and the start is dropped.
- `diff` is not guaranteed meaningful while `busy=1`. Consumers sample it only on `done`.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - On the last SHIFT edge, `ovf <= (a_msb != b_msb) && (d != a_msb)`, where `a_msb` and `b_msb` are the operand MSBs shifted in that cycle and `d` is the MSB difference bit.
  - `ovf` is held with `diff`, cleared on acceptance of a new start, and cleared by reset.
- Undefined:
  - Port `ovf` and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- `a=0x05`, `b=0x03`, `bin=0` -> after 8 cycles `done` pulses 1 cycle with `diff=0x02`, `bout=0`, `ovf=0`.
- `a=0x03`, `b=0x05`, `bin=0` -> `diff=0xFE`, `bout=1`. Then `a=0x00`, `b=0x00`, `bin=1` -> `diff=0xFF`, `bout=1`.
- `a=0x80`, `b=0x01`, `bin=0` -> `diff=0x7F`, `bout=0`, `ovf=1` (with the macro). `a=0x7F`, `b=0xFF` -> `diff=0x80`, `bout=1`, `ovf=1`.
- Reassert `start` with `a=0xAA` on the 3rd busy cycle, while the first operation is `a=0x10`, `b=0x01` -> the second start is ignored. The result is `diff=0x0F`, with exactly one `done`.
- Hold `start` in the DONE cycle with `a=0x20`, `b=0x10` -> new operation accepted, `busy` high on the next cycle, second `done` 8 cycles later with `diff=0x10`.
- Assert `rst` on the 4th busy cycle -> the next cycle shows `busy=0`, `done=0`, `diff=0x00`, `bout=0`. No `done` ever appears for the aborted operation, and a following start behaves normally.
